// File: rtl/asr_mem_pkg.sv
// Shared constants and bank-state encoding for the MFCC RAM writer slice.
package asr_mem_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned FRAME_LEN   = 128;
  localparam int unsigned MFCC_ADDR_W = 7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/mfcc_bank_ctrl.sv
// Bank occupancy tracking for the MFCC writer: per-bank EMPTY/FULL state,
// the reader's bank pointer and the registered frame_ready flag.
// MFCC_WRITER_PINGPONG_EN selects two banks; otherwise only bank 0 is used.
module mfcc_bank_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic commit,
  input  logic commit_bank,
  input  logic wr_bank,
  input  logic frame_release,
  output logic wr_bank_full,
  output logic rd_bank,
  output logic frame_ready
);
  import asr_mem_pkg::*;

  bank_state_t [1:0] bank_state;
  logic              release_ok;

  assign release_ok   = frame_release & frame_ready;
  assign wr_bank_full = (bank_state[wr_bank] == FULL);

  // Bank state machines and frame_ready. frame_ready looks at the state
  // before this edge, so a freshly committed bank shows up one cycle after
  // its full flag, by which time the last RAM write has landed.
  // A commit targets an EMPTY bank and a release a FULL one, so the two
  // updates never hit the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state  <= {EMPTY, EMPTY};
      frame_ready <= 1'b0;
    end else begin
      if (commit)     bank_state[commit_bank] <= FULL;
      if (release_ok) bank_state[rd_bank]     <= EMPTY;
      if (release_ok) frame_ready <= (bank_state[~rd_bank] == FULL) && (~rd_bank != rd_bank);
      else            frame_ready <= (bank_state[rd_bank] == FULL);
    end
  end

`ifdef MFCC_WRITER_PINGPONG_EN
  // Reader moves to the other bank on every honoured release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rd_bank <= 1'b0;
    else if (release_ok) rd_bank <= ~rd_bank;
  end
`else
  assign rd_bank = 1'b0;
`endif

endmodule

// File: rtl/mfcc_mem_writer.sv
// MFCC coefficient RAM writer: accepts a stream of coefficients, writes them
// one cycle later as {bank, offset} into the MFCC RAM and hands completed
// frames to the MAC reader.
// Define MFCC_WRITER_PINGPONG_EN for two ping-pong banks; the default build
// uses a single bank that stalls until the reader releases it.
module mfcc_mem_writer #(
  parameter int unsigned DATA_WIDTH = asr_mem_pkg::DATA_WIDTH,
  parameter int unsigned FRAME_LEN  = asr_mem_pkg::FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  mem_wr_en,
  output logic [7:0]            mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  rd_bank,
  output logic                  frame_ready,
  input  logic                  frame_release
);
  import asr_mem_pkg::*;

  localparam logic [MFCC_ADDR_W-1:0] LAST_OFFSET = MFCC_ADDR_W'(FRAME_LEN - 1);

  logic [MFCC_ADDR_W-1:0] offset;
  logic                   wr_bank;
  logic                   wr_bank_full;
  logic                   started;
  logic                   accept;
  logic                   last_beat;

  assign in_ready  = started & ~flush & ~wr_bank_full;
  assign accept    = in_valid & in_ready;
  assign last_beat = accept & (offset == LAST_OFFSET);

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  // Word offset within the frame being written; flush restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         offset <= '0;
    else if (flush)     offset <= '0;
    else if (last_beat) offset <= '0;
    else if (accept)    offset <= offset + MFCC_ADDR_W'(1);
  end

`ifdef MFCC_WRITER_PINGPONG_EN
  // Writer moves to the other bank once a frame is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wr_bank <= 1'b0;
    else if (last_beat) wr_bank <= ~wr_bank;
  end
`else
  assign wr_bank = 1'b0;
`endif

  // Registered RAM write port: one cycle from acceptance to strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= accept;
      if (accept) begin
        mem_wr_addr <= {wr_bank, offset};
        mem_wr_data <= in_data;
      end
    end
  end

  mfcc_bank_ctrl u_bank_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .commit        (last_beat),
    .commit_bank   (wr_bank),
    .wr_bank       (wr_bank),
    .frame_release (frame_release),
    .wr_bank_full  (wr_bank_full),
    .rd_bank       (rd_bank),
    .frame_ready   (frame_ready)
  );

endmodule

// File: tb/tb_mfcc_mem_writer.sv
// Self-checking bench for mfcc_mem_writer (default FRAME_LEN=128, DATA_WIDTH=32).
// Expected RAM writes go into a scoreboard queue when a beat is predicted to be
// accepted and are popped when the write strobe appears.
module tb_mfcc_mem_writer;

  localparam int DW = 32;
  localparam int FL = 128;
`ifdef MFCC_WRITER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          rd_bank;
  logic          frame_ready;
  logic          frame_release = 1'b0;

  mfcc_mem_writer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .flush         (flush),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .rd_bank       (rd_bank),
    .frame_ready   (frame_ready),
    .frame_release (frame_release)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (valid between edges)
  int       m_off;
  bit       m_wb, m_rb, m_fr, m_run;
  bit [1:0] m_full;
  logic [8+DW-1:0] sb[$];

  bit rdy_seen, fr_seen, rb_seen;

  // One clock cycle: check registered outputs, drive inputs, predict, advance model.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
    bit exp_rdy, acc, last, rel, nrb;
    @(negedge clk);
    fr_seen = frame_ready;
    rb_seen = rd_bank;
    chk("frame_ready", frame_ready, m_fr);
    chk("rd_bank", rd_bank, m_rb);
    in_valid = v; in_data = d; flush = f; frame_release = r;
    #1;
    rdy_seen = in_ready;
    exp_rdy = m_run && !f && !m_full[m_wb];
    chk("in_ready", in_ready, exp_rdy);
    acc  = v && exp_rdy;
    last = acc && (m_off == FL - 1);
    rel  = r && m_fr;
    if (acc) sb.push_back({m_wb, 7'(m_off), d});
    nrb = m_rb ^ (rel & PP);
    @(posedge clk);
    // Reader sees a bank only if it was already full before this edge and is not the one being released.
    m_fr = m_full[nrb] && !(rel && nrb == m_rb);
    if (rel)  m_full[m_rb] = 1'b0;
    if (last) m_full[m_wb] = 1'b1;
    m_rb  = nrb;
    m_wb  = m_wb ^ (last & PP);
    m_off = (f || last) ? 0 : (acc ? m_off + 1 : m_off);
    m_run = 1'b1;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = '1; flush = 1'b0; frame_release = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sb_empty", sb.size(), 0);
    m_off = 0; m_wb = 0; m_rb = 0; m_fr = 0; m_run = 0; m_full = '0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 0);
    @(posedge clk);
    m_run = 1'b1;
  endtask

  // Write monitor: strobe must appear exactly when a write is pending.
  initial begin
    logic [8+DW-1:0] e;
    bit exp_en;
    forever begin
      @(posedge clk);
      #1;
      exp_en = (sb.size() != 0);
      chk("wr_en", mem_wr_en, exp_en);
      if (exp_en) begin
        e = sb.pop_front();
        if (mem_wr_en) begin
          chk("wr_addr", mem_wr_addr, e[8+DW-1:DW]);
          chk("wr_data", mem_wr_data, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          f;
    bit          r;
    bit          exp_rdy;
    bit          exp_fr;
  } vec_t;

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1, 32'h11, 0, 0, 1, 0};
    tbl[1] = '{1, 32'h22, 0, 0, 1, 0};
    tbl[2] = '{0, 32'h00, 0, 0, 1, 0};
    tbl[3] = '{1, 32'h33, 1, 0, 0, 0};  // flush blocks the beat
    tbl[4] = '{1, 32'h44, 0, 0, 1, 0};  // lands at offset 0
    tbl[5] = '{1, 32'h55, 0, 1, 1, 0};  // release with no frame: ignored
    tbl[6] = '{0, 32'h00, 1, 0, 0, 0};
    tbl[7] = '{0, 32'h00, 0, 0, 1, 0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_rdy", i), rdy_seen, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_fr", i), fr_seen, tbl[i].exp_fr);
    end

    // Full frame of data=i into bank 0
    fill(FL, 32'h0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("frame0_fr_t1", fr_seen, 0);
    chk("frame0_rdy_t1", rdy_seen, PP);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("frame0_fr_t2", fr_seen, 1);
    chk("frame0_rd_bank", rb_seen, 0);

`ifdef MFCC_WRITER_PINGPONG_EN
    // Bank 1: last beat coincides with release of bank 0
    fill(FL - 1, 32'h200);
    step(1'b1, 32'h27F, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pp_rd_bank_swap", rb_seen, 1);
    chk("pp_rdy_after_swap", rdy_seen, 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pp_frame1_ready", fr_seen, 1);
    // Fill bank 0 again without release: both banks full, writer stalls
    fill(FL, 32'h300);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("pp_hold_rdy", rdy_seen, 0);
    step(1'b1, 32'hBEEF, 1'b0, 1'b1);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("pp_resume_rdy", rdy_seen, 1);
`else
    // Single bank: beat held until release, then frame rewrites 0x00..0x7F
    for (int i = 0; i < 4; i++) step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("sb_hold_rdy", rdy_seen, 0);
    step(1'b1, 32'hBEEF, 1'b0, 1'b1);
    chk("sb_release_cycle_rdy", rdy_seen, 0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    chk("sb_refill_rdy", rdy_seen, 1);
    chk("sb_refill_fr", fr_seen, 0);
    fill(FL - 1, 32'h101);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_frame2_fr", fr_seen, 1);
    step(1'b0, '0, 1'b0, 1'b1);
`endif

    // Flush after 50 beats: next beat restarts at offset 0 of the same bank
    fill(50, 32'h400);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'hF00D, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of a frame
    fill(60, 32'h500);
    do_reset();
    step(1'b1, 32'hCAFE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
